// File: rtl/itcm_boot_arb.sv
// ITCM owner: streams a boot image from the loader, then arbitrates each cycle
// between CPU fetch (priority) and debug writes with a starvation limit.
module itcm_boot_arb #(
  parameter int PC_WIDTH   = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [31:0]         ld_data,
  input  logic                ld_last,
  output logic                cpu_en,
  output logic                load_done,
  output logic                load_err,
  input  logic                rd_insn_en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         insn,
  output logic                insn_valid,
  output logic                fetch_stall,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [31:0]         dbg_wdata,
  output logic                dbg_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [SW-1:0]     starve;
  logic              rd_pend;
  logic [31:0]       insn_hold;

  logic in_load, in_run, ld_xfer, dbg_gnt, fetch_gnt;
  logic unused_pc;

  // Reset masks the combinational grants so an abort never issues an access.
  assign in_load   = (state == S_LOAD) && !rst;
  assign in_run    = (state == S_RUN) && !rst;
  assign ld_xfer   = in_load && ld_valid;
  assign dbg_gnt   = in_run && !boot_start && dbg_req &&
                     (!rd_insn_en || starve == SW'(STARVE_MAX));
  assign fetch_gnt = in_run && !boot_start && rd_insn_en && !dbg_gnt;

  assign ld_ready    = in_load;
  assign dbg_ack     = dbg_gnt;
  assign fetch_stall = dbg_gnt && rd_insn_en;
  assign mem_en      = ld_xfer || dbg_gnt || fetch_gnt;
  assign mem_we      = ld_xfer || dbg_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_xfer) begin
      mem_addr  = cnt;
      mem_wdata = ld_data;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (fetch_gnt) begin
      mem_addr  = pc[ADDR_W+1:2];
    end
  end

  // ITCM read data lands one cycle after the grant; hold it afterwards.
  assign insn_valid = rd_pend;
  assign insn       = rd_pend ? mem_rdata : insn_hold;
  assign unused_pc  = ^{pc[PC_WIDTH-1:ADDR_W+2], pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      starve    <= '0;
      rd_pend   <= 1'b0;
      insn_hold <= '0;
      cpu_en    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rd_pend <= fetch_gnt;
      if (rd_pend) insn_hold <= mem_rdata;
      if (in_run && dbg_req && !dbg_gnt && !boot_start) starve <= starve + 1'b1;
      else                                               starve <= '0;
      case (state)
        S_IDLE: if (boot_start) begin
          state     <= S_LOAD;
          cnt       <= '0;
          load_done <= 1'b0;
          load_err  <= 1'b0;
        end
        S_LOAD: if (ld_valid) begin
          if (ld_last) begin
            state     <= S_RUN;
            load_done <= 1'b1;
            cpu_en    <= 1'b1;
          end else if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= S_IDLE;
            load_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: if (boot_start) begin
          state     <= S_LOAD;
          cpu_en    <= 1'b0;
          cnt       <= '0;
          load_done <= 1'b0;
          load_err  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_itcm_boot_arb.sv
// Randomized bench for itcm_boot_arb with a behavioural ITCM and a spec-level
// reference model (expected memory image, grant rules, fetch latency).
module tb_itcm_boot_arb;
  localparam int PC_WIDTH = 32, ADDR_W = 10, DEPTH = 1024, STARVE_MAX = 4;

  logic clk = 0, rst = 1;
  logic boot_start = 0, ld_valid = 0, ld_last = 0, rd_insn_en = 0, dbg_req = 0;
  logic [31:0] ld_data = 0, dbg_wdata = 0, mem_rdata = 0;
  logic [PC_WIDTH-1:0] pc = 0;
  logic [ADDR_W-1:0] dbg_addr = 0;
  logic ld_ready, cpu_en, load_done, load_err, insn_valid, fetch_stall, dbg_ack;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] insn, mem_wdata;

  always #5 clk = ~clk;

  itcm_boot_arb #(.PC_WIDTH(PC_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .cpu_en(cpu_en), .load_done(load_done),
    .load_err(load_err), .rd_insn_en(rd_insn_en), .pc(pc), .insn(insn), .insn_valid(insn_valid),
    .fetch_stall(fetch_stall), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // behavioural single-port ITCM, 1-cycle read latency
  logic [31:0] ram [DEPTH];
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else        mem_rdata <= ram[mem_addr];
  end

  // reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] img [3];
  logic [31:0] last_insn = 0, pdata = 0;
  logic [ADDR_W-1:0] paddr = 0, prev_addr = 0;
  bit pend = 0, prev_fetch = 0;
  int starve = 0, ack_cyc = -1;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    pend = 0; starve = 0; prev_fetch = 0;
  endtask

  // boot: issue boot_start pulse first; fixed: use img[] densely
  task automatic do_load(input int n, input bit set_last, input bit dense, input bit fixed, input bit boot);
    int idx = 0, cyc = 0;
    bit done = 0;
    model_clear();
    if (boot) begin
      @(negedge clk); boot_start = 1; ld_valid = 0; rd_insn_en = 0; dbg_req = 0;
      #1 chk("boot_mem_en", mem_en, 0);
    end
    while (!done && cyc < 5000) begin
      @(negedge clk);
      boot_start = ($urandom_range(7) == 0);
      ld_valid   = (dense || fixed) ? 1'b1 : ($urandom_range(3) != 0);
      ld_data    = fixed ? img[idx] : $urandom;
      ld_last    = set_last && (idx == n - 1);
      rd_insn_en = $urandom_range(1);
      dbg_req    = $urandom_range(1);
      pc         = $urandom;
      #1;
      chk("ld_ready", ld_ready, 1);
      chk("load_cpu_en", cpu_en, 0);
      chk("load_stall", fetch_stall, 0);
      chk("load_dbg_ack", dbg_ack, 0);
      chk("load_mem_en", mem_en, ld_valid);
      if (ld_valid) begin
        chk("load_we", mem_we, 1);
        chk("load_addr", mem_addr, idx);
        chk("load_wdata", mem_wdata, ld_data);
        ref_mem[idx] = ld_data;
        if (ld_last || idx == DEPTH - 1) done = 1;
        idx++;
      end
      cyc++;
    end
    if (!done) chk("load_timeout", 0, 1);
    @(negedge clk);
    boot_start = 0; ld_valid = 0; ld_last = 0; rd_insn_en = 0; dbg_req = 0;
    #1;
    chk("post_ld_ready", ld_ready, 0);
    chk("post_mem_en", mem_en, 0);
    if (set_last) begin
      chk("post_cpu_en", cpu_en, 1);
      chk("post_done", load_done, 1);
      chk("post_err", load_err, 0);
    end else begin
      chk("ovf_cpu_en", cpu_en, 0);
      chk("ovf_done", load_done, 0);
      chk("ovf_err", load_err, 1);
    end
  endtask

  task automatic do_run(input int n, input bit force_both);
    bit fetch, dg, fg;
    ack_cyc = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fetch = force_both ? 1'b1 : bit'($urandom_range(1));
      if (!pend && (force_both || $urandom_range(2) == 0)) begin
        pend  = 1;
        paddr = force_both ? ADDR_W'(5) : ADDR_W'($urandom);
        pdata = force_both ? 32'hDEADBEEF : $urandom;
      end
      rd_insn_en = fetch; pc = $urandom;
      dbg_req = pend; dbg_addr = paddr; dbg_wdata = pdata;
      ld_valid = $urandom_range(1); boot_start = 0;
      #1;
      dg = pend && (!fetch || starve == STARVE_MAX);
      fg = fetch && !dg;
      chk("run_cpu_en", cpu_en, 1);
      chk("run_ld_ready", ld_ready, 0);
      chk("insn_valid", insn_valid, prev_fetch);
      if (prev_fetch) last_insn = ref_mem[prev_addr];
      chk("insn", insn, last_insn);
      chk("run_mem_en", mem_en, fg || dg);
      chk("run_mem_we", mem_we, dg);
      chk("dbg_ack", dbg_ack, dg);
      chk("fetch_stall", fetch_stall, fetch && dg);
      if (fg) chk("fetch_addr", mem_addr, pc[ADDR_W+1:2]);
      if (dg) begin
        chk("dbg_addr", mem_addr, paddr);
        chk("dbg_wdata", mem_wdata, pdata);
        ref_mem[paddr] = pdata;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (!pend || dg) starve = 0;
      else starve++;
      if (dg) pend = 0;
      prev_fetch = fg; prev_addr = pc[ADDR_W+1:2];
    end
    ld_valid = 0;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    img[0] = 32'h00000013; img[1] = 32'h00100093; img[2] = 32'h0000006F;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_en", cpu_en, 0); chk("rst_ld_ready", ld_ready, 0);
    chk("rst_done", load_done, 0); chk("rst_err", load_err, 0);
    chk("rst_insn", insn, 0); chk("rst_insn_valid", insn_valid, 0);
    chk("rst_mem_en", mem_en, 0); chk("rst_dbg_ack", dbg_ack, 0);
    @(negedge clk); rst = 0;
    rd_insn_en = 1; #1;
    chk("idle_stall", fetch_stall, 0); chk("idle_mem_en", mem_en, 0);
    @(negedge clk); rd_insn_en = 0; #1 chk("idle_insn_valid", insn_valid, 0);

    // fixed 3-word image, then directed fetch with address wrap
    do_load(3, 1, 1, 1, 1);
    @(negedge clk); rd_insn_en = 1; pc = 32'h8; #1;
    chk("pc8_addr", mem_addr, 2); chk("pc8_we", mem_we, 0);
    @(negedge clk); pc = 32'h1008; #1;
    chk("pc8_insn", insn, 32'h0000006F); chk("pc8_valid", insn_valid, 1);
    chk("wrap_addr", mem_addr, 2);
    @(negedge clk); rd_insn_en = 0; #1;
    chk("wrap_insn", insn, 32'h0000006F); chk("wrap_valid", insn_valid, 1);
    last_insn = 32'h0000006F; prev_fetch = 0;

    // starvation limit: four fetch grants, then debug forced
    do_run(7, 1);
    chk("starve_ack_cycle", ack_cyc, STARVE_MAX);
    chk("ram5", ram[5], 32'hDEADBEEF);

    do_run(300, 0);

    // boot_start in RUN with a debug request pending
    @(negedge clk); boot_start = 1; rd_insn_en = 0; dbg_req = 1; dbg_addr = 7; dbg_wdata = $urandom; #1;
    chk("reboot_ack", dbg_ack, 0); chk("reboot_mem_en", mem_en, 0);
    @(negedge clk); boot_start = 0; #1;
    chk("reboot_cpu_en", cpu_en, 0); chk("reboot_ld_ready", ld_ready, 1); chk("reboot_ack2", dbg_ack, 0);
    do_load(20, 1, 0, 0, 0);
    do_run(200, 0);

    // reset after two accepted words
    @(negedge clk); boot_start = 1; rd_insn_en = 0; dbg_req = 0;
    @(negedge clk); boot_start = 0; ld_valid = 1; ld_data = $urandom; #1;
    chk("abort_addr0", mem_addr, 0); ref_mem[0] = ld_data;
    @(negedge clk); ld_data = $urandom; #1;
    chk("abort_addr1", mem_addr, 1); ref_mem[1] = ld_data;
    @(negedge clk); rst = 1; ld_valid = 0;
    @(negedge clk); rst = 0; #1;
    chk("abort_ld_ready", ld_ready, 0); chk("abort_cpu_en", cpu_en, 0);
    chk("abort_done", load_done, 0); chk("abort_insn", insn, 0);
    chk("abort_valid", insn_valid, 0); chk("abort_mem_en", mem_en, 0);
    last_insn = 0;
    do_load(10, 1, 0, 0, 1);
    do_run(150, 0);

    // overflow: 1024 words without ld_last
    do_load(DEPTH, 0, 1, 0, 1);
    @(negedge clk); rd_insn_en = 1; dbg_req = 1; #1;
    chk("ovf_idle_mem_en", mem_en, 0); chk("ovf_idle_stall", fetch_stall, 0);
    chk("ovf_idle_cpu_en", cpu_en, 0);
    @(negedge clk); rd_insn_en = 0; dbg_req = 0; #1 chk("ovf_idle_valid", insn_valid, 0);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("itcm_image_mismatches", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
